load_store_unit: RTL and testbench

- Sits between the pipeline MEM stage and the word-only data memory (DATA segment 0x1000xxxx, STACK segment 0x7fffxxxx).
- Accepts one load/store request at a time and performs the word access.
- Sub-word stores are done as read-modify-write. Sub-word loads are extracted with sign or zero extension.
- Raises alignment, segment and illegal-op faults, and returns a one-cycle response to the pipeline.

---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-only data memory.
// Sub-word stores use read-modify-write; sub-word loads are extended here.
module load_store_unit #(
    parameter int          RD_LATENCY = 1,
    parameter logic [15:0] DATA_SEG   = 16'h1000,
    parameter logic [15:0] STACK_SEG  = 16'h7fff
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic [3:0]  req_op_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        resp_valid_out,
    output logic [31:0] rdata_out,
    output logic        fault_out,
    output logic [1:0]  fault_code_out,
    output logic        stall_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_writedata_out,
    output logic        mem_re_out,
    output logic        mem_we_out,
    input  logic [31:0] mem_readdata_in
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  op_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [1:0]  cnt;

    logic        accept;
    logic        legal;
    logic        misaligned;
    logic        seg_bad;
    logic [1:0]  code;
    logic        sample;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign req_ready_out = (state == IDLE);
    assign stall_out     = !req_ready_out;
    assign accept        = req_valid_in && req_ready_out;

    always_comb begin
        legal = 1'b0;
        case (req_op_in)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        misaligned = ((req_op_in[1:0] == 2'd1) && addr_in[0])
                  || ((req_op_in[1:0] == 2'd2) && (addr_in[1:0] != 2'd0));
        seg_bad = (addr_in[31:16] != DATA_SEG) && (addr_in[31:16] != STACK_SEG);
        // Illegal op outranks misalignment, which outranks segment.
        if (!legal)
            code = 2'd3;
        else if (misaligned)
            code = 2'd1;
        else if (seg_bad)
            code = 2'd2;
        else
            code = 2'd0;
    end

    assign sample = ((state == READ) && (RD_LATENCY == 0))
                 || ((state == WAIT) && (cnt == 2'd0));

    always_comb begin
        byte_v   = mem_readdata_in[{lane_q, 3'b000} +: 8];
        half_v   = lane_q[1] ? mem_readdata_in[31:16] : mem_readdata_in[15:0];
        load_val = mem_readdata_in;
        case (op_q[1:0])
            2'd0: load_val = {{24{byte_v[7] & ~op_q[2]}}, byte_v};
            2'd1: load_val = {{16{half_v[15] & ~op_q[2]}}, half_v};
            default: load_val = mem_readdata_in;
        endcase
        merged = mem_readdata_in;
        if (op_q[1:0] == 2'd0)
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else if (lane_q[1])
            merged[31:16] = wdata_q;
        else
            merged[15:0] = wdata_q;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (code != 2'd0)
                        state_next = RESP;
                    else if (req_op_in == 4'd10)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ: begin
                if (RD_LATENCY == 0)
                    state_next = op_q[3] ? WRITE : RESP;
                else
                    state_next = WAIT;
            end
            WAIT: begin
                if (cnt == 2'd0)
                    state_next = op_q[3] ? WRITE : RESP;
            end
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            op_q              <= 4'd0;
            lane_q            <= 2'd0;
            wdata_q           <= 16'd0;
            cnt               <= 2'd0;
            resp_valid_out    <= 1'b0;
            rdata_out         <= 32'd0;
            fault_out         <= 1'b0;
            fault_code_out    <= 2'd0;
            mem_re_out        <= 1'b0;
            mem_we_out        <= 1'b0;
            mem_addr_out      <= 32'd0;
            mem_writedata_out <= 32'd0;
        end else begin
            state          <= state_next;
            mem_re_out     <= (state_next == READ);
            mem_we_out     <= (state_next == WRITE);
            resp_valid_out <= (state_next == RESP);
            if (accept) begin
                op_q              <= req_op_in;
                lane_q            <= addr_in[1:0];
                wdata_q           <= wdata_in[15:0];
                mem_addr_out      <= {addr_in[31:2], 2'b00};
                mem_writedata_out <= wdata_in;
                fault_out         <= (code != 2'd0);
                fault_code_out    <= code;
            end else if (state == RESP) begin
                fault_out      <= 1'b0;
                fault_code_out <= 2'd0;
            end
            if (state == READ)
                cnt <= 2'(RD_LATENCY - 1);
            else if (state == WAIT)
                cnt <= cnt - 2'd1;
            if (sample) begin
                if (op_q[3])
                    mem_writedata_out <= merged;
                else
                    rdata_out <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit at read latencies 1, 0 and 3,
// sharing one word memory model across the three instances.
module tb_load_store_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        vld[3];
    logic        ready[3];
    logic [3:0]  op[3];
    logic [31:0] addr[3];
    logic [31:0] wdata[3];
    logic        resp[3];
    logic [31:0] rdata[3];
    logic        fault[3];
    logic [1:0]  fcode[3];
    logic        stall[3];
    logic [31:0] maddr[3];
    logic [31:0] mwdata[3];
    logic        mre[3];
    logic        mwe[3];
    logic [31:0] mrdata[3];

    logic [31:0] mem[16];
    logic [31:0] pipe[3][3];

    function automatic logic [3:0] idx(input logic [31:0] a);
        return {a[30], a[4:2]};
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 0 : 3;
    endfunction

    always @(posedge clock) begin
        for (int g = 0; g < 3; g++) begin
            if (mwe[g]) mem[idx(maddr[g])] <= mwdata[g];
            pipe[g][0] <= mem[idx(maddr[g])];
            pipe[g][1] <= pipe[g][0];
            pipe[g][2] <= pipe[g][1];
        end
    end

    for (genvar g = 0; g < 3; g++) begin : lsu
        localparam int L = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        load_store_unit #(.RD_LATENCY(L)) dut (
            .clock(clock),
            .reset(reset),
            .req_valid_in(vld[g]),
            .req_ready_out(ready[g]),
            .req_op_in(op[g]),
            .addr_in(addr[g]),
            .wdata_in(wdata[g]),
            .resp_valid_out(resp[g]),
            .rdata_out(rdata[g]),
            .fault_out(fault[g]),
            .fault_code_out(fcode[g]),
            .stall_out(stall[g]),
            .mem_addr_out(maddr[g]),
            .mem_writedata_out(mwdata[g]),
            .mem_re_out(mre[g]),
            .mem_we_out(mwe[g]),
            .mem_readdata_in(mrdata[g])
        );
        if (L == 0) begin : comb_rd
            assign mrdata[g] = mem[idx(maddr[g])];
        end else begin : pipe_rd
            assign mrdata[g] = pipe[g][L-1];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    int          lat, nre, nwe, we_cyc;
    logic [31:0] r_rdata, r_wword;
    logic        r_fault, busy_ok;
    logic [1:0]  r_code;
    logic [31:0] last_ld[3];

    task automatic xact(input int g, input logic [3:0] o,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit hold);
        @(negedge clock);
        check("ready_idle", 32'(ready[g]), 32'd1);
        op[g] = o; addr[g] = a; wdata[g] = d; vld[g] = 1'b1;
        @(posedge clock);
        #1 if (!hold) vld[g] = 1'b0;
        lat = 0; nre = 0; nwe = 0; we_cyc = 0; busy_ok = 1'b1;
        r_wword = 32'd0;
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            @(negedge clock);
            if (ready[g] || !stall[g]) busy_ok = 1'b0;
            if (mre[g]) nre++;
            if (mwe[g]) begin nwe++; we_cyc = n; r_wword = mwdata[g]; end
            if (resp[g]) begin
                lat = n; r_rdata = rdata[g];
                r_fault = fault[g]; r_code = fcode[g];
            end
        end
    endtask

    task automatic ld(input int g, input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] exp, input string tag, input bit hold);
        xact(g, o, a, 32'd0, hold);
        check({tag, "_lat"}, lat, 2 + lat_of(g));
        check({tag, "_data"}, r_rdata, exp);
        check({tag, "_flt"}, {r_fault, r_code}, 32'd0);
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        last_ld[g] = exp;
    endtask

    task automatic st(input int g, input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] expw,
                      input string tag, input bit hold);
        xact(g, o, a, d, hold);
        check({tag, "_lat"}, lat, (o == 4'd10) ? 2 : 3 + lat_of(g));
        check({tag, "_word"}, r_wword, expw);
        check({tag, "_nwe"}, nwe, 1);
        check({tag, "_nre"}, nre, (o == 4'd10) ? 0 : 1);
        check({tag, "_flt"}, {r_fault, r_code}, 32'd0);
        check({tag, "_rkeep"}, r_rdata, last_ld[g]);
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    endtask

    task automatic flt(input int g, input logic [3:0] o, input logic [31:0] a,
                       input logic [1:0] c, input string tag);
        xact(g, o, a, 32'h0000_00AA, 1'b0);
        check({tag, "_lat"}, lat, 1);
        check({tag, "_fault"}, 32'(r_fault), 32'd1);
        check({tag, "_code"}, 32'(r_code), 32'(c));
        check({tag, "_mem"}, nre + nwe, 0);
        check({tag, "_rkeep"}, r_rdata, last_ld[g]);
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            vld[g] = 1'b0; op[g] = 4'd0; addr[g] = 32'd0;
            wdata[g] = 32'd0; last_ld[g] = 32'd0;
        end
        vld[0] = 1'b1;
        op[0] = 4'd2;
        addr[0] = 32'h1000_0000;
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(ready[0]), 32'd1);
        check("rst_outs", {resp[0], fault[0], fcode[0], mre[0], mwe[0]}, 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_maddr", maddr[0], 32'd0);
        check("rst_mwdata", mwdata[0], 32'd0);
        reset = 1'b0;
        vld[0] = 1'b0;

        st(0, 4'd10, 32'h1000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "sw1", 0);
        check("sw1_wecyc", we_cyc, 1);
        ld(0, 4'd2, 32'h1000_0004, 32'hDEAD_BEEF, "lw1", 0);

        st(0, 4'd10, 32'h7fff_0010, 32'h1122_3344, 32'h1122_3344, "sw2", 0);
        ld(0, 4'd0, 32'h7fff_0013, 32'h0000_0011, "lb", 0);
        ld(0, 4'd4, 32'h7fff_0013, 32'h0000_0011, "lbu", 0);
        ld(0, 4'd1, 32'h7fff_0012, 32'h0000_1122, "lh", 0);
        ld(0, 4'd5, 32'h7fff_0012, 32'h0000_1122, "lhu", 0);
        st(0, 4'd10, 32'h7fff_0010, 32'h80FF_8001, 32'h80FF_8001, "sw3", 0);
        ld(0, 4'd0, 32'h7fff_0012, 32'hFFFF_FFFF, "lb_neg", 0);
        ld(0, 4'd4, 32'h7fff_0012, 32'h0000_00FF, "lbu_ff", 0);
        ld(0, 4'd5, 32'h7fff_0010, 32'h0000_8001, "lhu_lo", 0);
        ld(0, 4'd1, 32'h7fff_0010, 32'hFFFF_8001, "lh_neg", 0);

        st(0, 4'd10, 32'h1000_0000, 32'hAABB_CCDD, 32'hAABB_CCDD, "sw4", 0);
        st(0, 4'd8, 32'h1000_0001, 32'h0000_0055, 32'hAABB_55DD, "sb", 0);
        st(0, 4'd9, 32'h1000_0002, 32'h0000_1234, 32'h1234_55DD, "sh", 0);
        ld(0, 4'd2, 32'h1000_0000, 32'h1234_55DD, "lw_rmw", 0);

        flt(0, 4'd2, 32'h1000_0002, 2'd1, "f_mis");
        flt(0, 4'd2, 32'h2000_0000, 2'd2, "f_seg");
        flt(0, 4'hF, 32'h2000_0001, 2'd3, "f_ill");
        flt(0, 4'd1, 32'h2000_0001, 2'd1, "f_prio");
        flt(0, 4'd8, 32'h3000_0000, 2'd2, "f_sbseg");
        flt(0, 4'd3, 32'h1000_0000, 2'd3, "f_op3");

        @(negedge clock);
        op[0] = 4'd9; addr[0] = 32'h1000_0002; wdata[0] = 32'h0000_BEEF;
        vld[0] = 1'b1;
        @(posedge clock);
        #1 vld[0] = 1'b0;
        for (int n = 0; n < 10 && !mwe[0]; n++) @(negedge clock);
        check("rst_mid_we", 32'(mwe[0]), 32'd1);
        reset = 1'b1;
        vld[0] = 1'b1;
        op[0] = 4'd2;
        addr[0] = 32'h1000_0000;
        @(negedge clock);
        check("rst_mid_out", {mwe[0], resp[0], mre[0]}, 32'd0);
        check("rst_mid_rdy", {ready[0], stall[0]}, 32'd2);
        @(negedge clock);
        check("rst_hold_rdy", {ready[0], mre[0]}, 32'd2);
        reset = 1'b0;
        vld[0] = 1'b0;
        @(negedge clock);
        check("rst_after", {ready[0], mre[0], resp[0]}, 32'd4);

        for (int g = 1; g < 3; g++) begin
            st(g, 4'd10, 32'h1000_0008, 32'h0102_0304, 32'h0102_0304, "b2b_sw", 1);
            ld(g, 4'd2, 32'h1000_0008, 32'h0102_0304, "b2b_lw", 1);
            st(g, 4'd8, 32'h1000_0009, 32'h0000_00AA, 32'h0102_AA04, "b2b_sb", 1);
            ld(g, 4'd1, 32'h1000_000A, 32'h0000_0102, "b2b_lh", 1);
            ld(g, 4'd0, 32'h1000_0009, 32'hFFFF_FFAA, "b2b_lb", 1);
            @(negedge clock);
            vld[g] = 1'b0;
            @(negedge clock);
            check("b2b_idle", 32'(ready[g]), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
